mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 26 ++
 rtl/arb_grant_sel.sv | 24 ++
 rtl/mem_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for mem_bus_arbiter: FSM state encoding, bus owner codes
// and one-hot grant patterns used by arb_grant_sel.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  // One-hot grant vector: bit 0 = instruction master, bit 1 = data master
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_INST = 2'b01;
  localparam logic [1:0] GNT_DATA = 2'b10;

  // Round-robin pointer after a grant favours the other master
  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_INST) ? OWN_DATA : OWN_INST;
  endfunction

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational grant selector: two requests plus a preference pointer in,
// one-hot grant out. The pointer only breaks ties.
module arb_grant_sel
  import mem_bus_arbiter_pkg::*;
(
  input  logic       i_inst_req,
  input  logic       i_data_req,
  input  owner_t     i_ptr,
  output logic [1:0] o_grant
);

  // Single requester wins outright; on contention the pointer decides
  always_comb begin
    o_grant = GNT_NONE;
    if (i_inst_req && i_data_req) begin
      o_grant = (i_ptr == OWN_DATA) ? GNT_DATA : GNT_INST;
    end else if (i_data_req) begin
      o_grant = GNT_DATA;
    end else if (i_inst_req) begin
      o_grant = GNT_INST;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto a single request/ack
// memory bus with one outstanding transaction.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise the data master wins every simultaneous request.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        stallreq_from_if,
  output logic        stallreq_from_mem
);

  arb_state_t  r_state;
  owner_t      r_owner;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_idle;
  logic        w_done;
  logic [1:0]  w_grant;
  owner_t      w_ptr;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t      r_ptr;
  assign w_ptr = r_ptr;
`else
  assign w_ptr = OWN_DATA;
`endif

  // Handshake outputs are combinational so they can pulse in the request /
  // bus-ack cycle itself; gating with rst forces them low during reset.
  assign w_idle = rst && (r_state == ST_IDLE);
  assign w_done = rst && bus_data_ok &&
                  ((r_state == ST_DATA) || ((r_state == ST_ADDR) && bus_addr_ok));

  arb_grant_sel u_grant_sel (
    .i_inst_req (inst_req && w_idle),
    .i_data_req (data_req && w_idle),
    .i_ptr      (w_ptr),
    .o_grant    (w_grant)
  );

  assign inst_addr_ok = w_grant[0];
  assign data_addr_ok = w_grant[1];
  assign inst_data_ok = w_done && (r_owner == OWN_INST);
  assign data_data_ok = w_done && (r_owner == OWN_DATA);
  assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
  assign data_rdata   = data_data_ok ? bus_rdata : '0;

  assign bus_req   = (r_state == ST_ADDR);
  assign bus_wr    = r_wr;
  assign bus_size  = r_size;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;

  assign stallreq_from_if  = rst &&
    ((inst_req && !inst_addr_ok) ||
     ((r_owner == OWN_INST) && (r_state != ST_IDLE) && !inst_data_ok));
  assign stallreq_from_mem = rst &&
    ((data_req && !data_addr_ok) ||
     ((r_owner == OWN_DATA) && (r_state != ST_IDLE) && !data_data_ok));

  // Transaction FSM: grant and capture in IDLE, address phase, data phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_INST;
      r_wr    <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_ptr   <= OWN_DATA;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant != GNT_NONE) begin
            r_state <= ST_ADDR;
            if (w_grant == GNT_DATA) begin
              r_owner <= OWN_DATA;
              r_wr    <= data_wr;
              r_size  <= data_size;
              r_addr  <= data_addr;
              r_wdata <= data_wdata;
            end else begin
              r_owner <= OWN_INST;
              r_wr    <= inst_wr;
              r_size  <= inst_size;
              r_addr  <= inst_addr;
              r_wdata <= inst_wdata;
            end
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr <= other_owner((w_grant == GNT_DATA) ? OWN_DATA : OWN_INST);
`endif
          end
        end
        ST_ADDR: begin
          if (bus_addr_ok) begin
            r_state <= bus_data_ok ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus_data_ok) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized master/slave traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  logic        clk, rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        stallreq_from_if, stallreq_from_mem;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Master request state (index 0 = inst, 1 = data)
  bit          m_req[2];
  bit          m_wr[2];
  logic [1:0]  m_size[2];
  logic [31:0] m_addr[2], m_wdata[2];
  bit          rereq[2];
  int          new_req_pct = 0;

  // Outstanding transaction as seen by the model
  bit          t_busy, t_dphase, t_zl;
  int          t_who;
  bit          t_wr;
  logic [1:0]  t_size;
  logic [31:0] t_addr, t_wdata;
  int          last_win = 0;   // inst "granted last" after reset => data favoured
  int          cnt;

  // Slave behaviour knobs
  bit          rand_slave = 0, stray_en = 0, dir_zl = 0, force_rd = 0;
  int          dir_la = 0, dir_ld = 0;
  logic [31:0] rd_val;

  // Observation log
  int          cyc = -1;
  int          grant_log[$], grant_cyc[$], ddok_cyc[$];
  int          ev_iaok, ev_idok, ev_breq, n_idok;

  task automatic new_request(input int m);
    int r;
    r = $urandom_range(0, 2);
    m_req[m]   = 1'b1;
    m_wr[m]    = (m == 1) && ($urandom_range(0, 1) == 1);
    m_size[m]  = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : 2'd3;
    m_addr[m]  = $urandom;
    m_wdata[m] = $urandom;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_aok"},   {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    check_val({tag, "_dok"},   {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    check_val({tag, "_irdat"}, inst_rdata, 32'd0);
    check_val({tag, "_drdat"}, data_rdata, 32'd0);
    check_val({tag, "_busctl"}, {28'd0, bus_req, bus_wr, bus_size}, 32'd0);
    check_val({tag, "_busadr"}, bus_addr, 32'd0);
    check_val({tag, "_buswd"},  bus_wdata, 32'd0);
    check_val({tag, "_stall"},  {30'd0, stallreq_from_if, stallreq_from_mem}, 32'd0);
  endtask

  // One bus cycle: drive at posedge+1, check and advance model at negedge
  task automatic step();
    int   win;
    bit   e_done, e_aok, e_dok;
    logic [31:0] e_rd;
    @(posedge clk); #1;
    cyc++;
    inst_req = m_req[0]; inst_wr = m_wr[0]; inst_size = m_size[0];
    inst_addr = m_addr[0]; inst_wdata = m_wdata[0];
    data_req = m_req[1]; data_wr = m_wr[1]; data_size = m_size[1];
    data_addr = m_addr[1]; data_wdata = m_wdata[1];
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata = force_rd ? rd_val : $urandom;
    if (t_busy && !t_dphase) begin
      if (cnt == 0) begin bus_addr_ok = 1'b1; bus_data_ok = t_zl; end
      else cnt--;
    end else if (t_busy) begin
      if (cnt == 0) bus_data_ok = 1'b1;
      else begin
        cnt--;
        if (stray_en && $urandom_range(0, 3) == 0) bus_addr_ok = 1'b1;
      end
    end else if (stray_en) begin
      bus_addr_ok = ($urandom_range(0, 3) == 0);
      bus_data_ok = ($urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    win = -1;
    if (!t_busy) begin
      if (m_req[0] && m_req[1]) win = (RR && last_win == 1) ? 0 : 1;
      else if (m_req[1]) win = 1;
      else if (m_req[0]) win = 0;
    end
    e_done = t_busy && bus_data_ok && (t_dphase || bus_addr_ok);

    for (int m = 0; m < 2; m++) begin
      e_aok = (win == m);
      e_dok = e_done && (t_who == m);
      e_rd  = e_dok ? bus_rdata : 32'd0;
      if (m == 0) begin
        check_val("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, e_aok});
        check_val("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, e_dok});
        check_val("inst_rdata", inst_rdata, e_rd);
        check_val("stall_if", {31'd0, stallreq_from_if},
                  {31'd0, (m_req[0] && !e_aok) || (t_busy && t_who == 0 && !e_dok)});
      end else begin
        check_val("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, e_aok});
        check_val("data_data_ok", {31'd0, data_data_ok}, {31'd0, e_dok});
        check_val("data_rdata", data_rdata, e_rd);
        check_val("stall_mem", {31'd0, stallreq_from_mem},
                  {31'd0, (m_req[1] && !e_aok) || (t_busy && t_who == 1 && !e_dok)});
      end
    end
    check_val("bus_req", {31'd0, bus_req}, {31'd0, t_busy && !t_dphase});
    if (t_busy && !t_dphase) begin
      check_val("bus_wr",    {31'd0, bus_wr}, {31'd0, t_wr});
      check_val("bus_size",  {30'd0, bus_size}, {30'd0, t_size});
      check_val("bus_addr",  bus_addr, t_addr);
      check_val("bus_wdata", bus_wdata, t_wdata);
    end

    if (inst_addr_ok === 1'b1) begin ev_iaok = cyc; grant_log.push_back(0); grant_cyc.push_back(cyc); end
    if (data_addr_ok === 1'b1) begin grant_log.push_back(1); grant_cyc.push_back(cyc); end
    if (inst_data_ok === 1'b1) begin ev_idok = cyc; n_idok++; end
    if (data_data_ok === 1'b1) ddok_cyc.push_back(cyc);
    if (bus_req === 1'b1 && ev_breq < 0) ev_breq = cyc;

    if (win >= 0) begin
      t_busy = 1'b1; t_dphase = 1'b0; t_who = win; last_win = win;
      t_wr = m_wr[win]; t_size = m_size[win]; t_addr = m_addr[win]; t_wdata = m_wdata[win];
      if (rand_slave) begin cnt = $urandom_range(0, 3); t_zl = ($urandom_range(0, 2) == 0); end
      else begin cnt = dir_la; t_zl = dir_zl; end
      m_req[win] = 1'b0;
      if (rereq[win]) new_request(win);
    end else if (t_busy && !t_dphase && bus_addr_ok) begin
      if (bus_data_ok) t_busy = 1'b0;
      else begin t_dphase = 1'b1; cnt = rand_slave ? $urandom_range(0, 3) : dir_ld; end
    end else if (t_busy && t_dphase && bus_data_ok) begin
      t_busy = 1'b0;
    end
    for (int m = 0; m < 2; m++)
      if (!m_req[m] && new_req_pct > 0 && $urandom_range(0, 99) < new_req_pct) new_request(m);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b0;
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    #1 check_outputs_zero("rst_mid");
    inst_req = 1'b0; data_req = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    t_busy = 1'b0; t_dphase = 1'b0; last_win = 0;
  endtask

  task automatic settle();
    rereq[0] = 1'b0; rereq[1] = 1'b0; new_req_pct = 0;
    for (int i = 0; i < 60 && (t_busy || m_req[0] || m_req[1]); i++) step();
    check_val("settle_idle", {31'd0, t_busy || m_req[0] || m_req[1]}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    inst_req = 1'b1; inst_wr = 0; inst_size = 0; inst_addr = 32'h1234; inst_wdata = 0;
    data_req = 1'b1; data_wr = 1; data_size = 3; data_addr = 32'h5678; data_wdata = 0;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    ev_breq = -1;
    #2 check_outputs_zero("rst_init");
    inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single inst read with addr_ok one cycle after bus_req, data_ok the next
    m_req[0] = 1; m_wr[0] = 0; m_size[0] = 2'd3; m_addr[0] = 32'hBFC0_0000; m_wdata[0] = 0;
    dir_la = 1; dir_ld = 0; dir_zl = 0; force_rd = 1; rd_val = 32'h3C1D_0001;
    cyc = -1; ev_iaok = -1; ev_idok = -1; ev_breq = -1;
    repeat (5) step();
    check_val("t035_aok_cyc", ev_iaok, 0);
    check_val("t035_breq_cyc", ev_breq, 1);
    check_val("t035_dok_cyc", ev_idok, 3);
    force_rd = 0;

    // Zero-latency slave: one data_ok pulse per transfer
    n_idok = 0;
    m_req[0] = 1; m_addr[0] = 32'h0000_0040;
    dir_la = 0; dir_zl = 1;
    repeat (4) step();
    check_val("t038_ndok", n_idok, 1);
    dir_zl = 0;

    // Reset during data phase of a data read
    m_req[1] = 1; m_wr[1] = 0; m_size[1] = 2'd3; m_addr[1] = 32'h8000_2000; m_wdata[1] = 0;
    dir_la = 0; dir_ld = 5;
    for (int i = 0; i < 10 && !t_dphase; i++) step();
    check_val("t039_in_data", {31'd0, t_dphase}, 32'd1);
    do_reset();
    repeat (8) step();
    grant_log.delete();
    m_req[1] = 1; m_addr[1] = 32'h8000_2004;
    dir_ld = 0;
    repeat (3) step();
    check_val("t039_regrant", grant_log.size(), 1);
    settle();

    // Simultaneous inst read and data write
    grant_log.delete(); grant_cyc.delete(); ddok_cyc.delete();
    new_request(0);
    m_req[1] = 1; m_wr[1] = 1; m_size[1] = 2'd3; m_addr[1] = 32'h8000_1000; m_wdata[1] = 32'hDEAD_BEEF;
    rereq[0] = 1; rereq[1] = RR;
    dir_la = 0; dir_ld = 1;
    for (int i = 0; i < 40 && grant_log.size() < 4; i++) step();
    check_val("t036_ngrant", grant_log.size(), 4);
    if (grant_log.size() >= 4) begin
      check_val("t036_g0", grant_log[0], 1);
      check_val("t036_g1", grant_log[1], 0);
      check_val("t036_g2", grant_log[2], RR ? 1 : 0);
      check_val("t036_g3", grant_log[3], 0);
    end
    check_val("t036_nddok", {31'd0, ddok_cyc.size() >= 1}, 32'd1);
    if (ddok_cyc.size() >= 1 && grant_cyc.size() >= 2)
      check_val("t036_inst_gnt_cyc", grant_cyc[1], ddok_cyc[0] + 1);
    settle();

    // Random traffic with stray slave pulses and occasional resets
    rand_slave = 1; stray_en = 1; new_req_pct = 30;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step();
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
